// File: rtl/snake_score_keeper.sv
// snake_score_keeper: owns the game score, saturates it at SCORE_MAX and
// converts it to three BCD digits with a sequential double-dabble FSM.
// The digit registers are written only in LOAD, so the display never sees a
// half-converted value.
// Optional macro SNAKE_HIGH_SCORE_EN adds the best-score register (hi_score,
// new_high); without it both outputs are tied to zero.
module snake_score_keeper #(
    parameter int SCORE_MAX       = 999,
    parameter int POINTS_PER_FOOD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_start,
    input  logic       eat,
    input  logic       game_over,
    output logic [9:0] score,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [3:0] huns,
    output logic       busy,
    output logic [9:0] hi_score,
    output logic       new_high
);

    localparam logic [9:0]  MAX_C = 10'(SCORE_MAX);
    localparam logic [10:0] PTS_C = 11'(POINTS_PER_FOOD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int n = 0; n < 3; n++) begin
            if (v[n*4 +: 4] >= 4'd5) begin
                r[n*4 +: 4] = v[n*4 +: 4] + 4'd3;
            end else begin
                r[n*4 +: 4] = v[n*4 +: 4];
            end
        end
        return r;
    endfunction

    logic [9:0]  score_r;
    logic        frozen_r;
    logic        dirty_r;
    state_t      state_r, state_s;
    logic [9:0]  bin_r, bin_s;
    logic [11:0] bcd_r, bcd_s, adj_s;
    logic [3:0]  cnt_r, cnt_s;
    logic        load_s;
    logic [11:0] digits_r;
    logic        eat_ok_s;
    logic [10:0] sum_s;
    logic [9:0]  score_inc_s;
    logic        capture_s;

    // The sum is formed 11 bits wide so the compare against the limit cannot wrap.
    assign sum_s       = {1'b0, score_r} + PTS_C;
    assign score_inc_s = (sum_s > {1'b0, MAX_C}) ? MAX_C : sum_s[9:0];
    assign eat_ok_s    = eat && !frozen_r && (score_r < MAX_C);
    assign capture_s   = (state_r == IDLE) && dirty_r;
    assign adj_s       = bcd_adjust(bcd_r);

    // Score and freeze flag; game_start beats both eat and game_over.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_r  <= 10'd0;
            frozen_r <= 1'b0;
        end else if (game_start) begin
            score_r  <= 10'd0;
            frozen_r <= 1'b0;
        end else begin
            if (eat_ok_s) begin
                score_r <= score_inc_s;
            end
            if (game_over) begin
                frozen_r <= 1'b1;
            end
        end
    end

    // Dirty flag: a new score wins over the clear done at capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty_r <= 1'b0;
        end else if (game_start || eat_ok_s) begin
            dirty_r <= 1'b1;
        end else if (capture_s) begin
            dirty_r <= 1'b0;
        end
    end

    // Conversion FSM state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            bin_r   <= 10'd0;
            bcd_r   <= 12'd0;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            bin_r   <= bin_s;
            bcd_r   <= bcd_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and datapath logic: capture, ten add-3/shift steps, then load.
    always_comb begin
        state_s = state_r;
        bin_s   = bin_r;
        bcd_s   = bcd_r;
        cnt_s   = cnt_r;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (dirty_r) begin
                    bin_s   = score_r;
                    bcd_s   = 12'd0;
                    cnt_s   = 4'd0;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                {bcd_s, bin_s} = {adj_s[10:0], bin_r, 1'b0};
                cnt_s          = cnt_r + 4'd1;
                if (cnt_r == 4'd9) begin
                    state_s = LOAD;
                end else begin
                    state_s = SHIFT;
                end
            end
            LOAD: begin
                load_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Digit register: all three nibbles change on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_r <= 12'd0;
        end else if (load_s) begin
            digits_r <= bcd_r;
        end
    end

    assign score = score_r;
    assign huns  = digits_r[11:8];
    assign tens  = digits_r[7:4];
    assign ones  = digits_r[3:0];
    assign busy  = (state_r != IDLE);

`ifdef SNAKE_HIGH_SCORE_EN
    logic [9:0] final_s;
    logic [9:0] hi_r;
    logic       new_high_r;

    // The score a game ends with includes an eat arriving on the same edge.
    assign final_s = eat_ok_s ? score_inc_s : score_r;

    // Best score since reset; only a live (unfrozen, not restarted) game_over counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r       <= 10'd0;
            new_high_r <= 1'b0;
        end else if (game_over && !game_start && !frozen_r && (final_s > hi_r)) begin
            hi_r       <= final_s;
            new_high_r <= 1'b1;
        end else begin
            new_high_r <= 1'b0;
        end
    end

    assign hi_score = hi_r;
    assign new_high = new_high_r;
`else
    assign hi_score = 10'd0;
    assign new_high = 1'b0;
`endif

endmodule

// File: doc/snake_score_keeper.md
Name: snake_score_keeper

Overview:
Sequential owner of the game score. It counts food events and saturates at a limit. A multi-cycle double-dabble FSM converts the binary score into three BCD digits (ones, tens, hundreds) for the score display, so the display path needs no combinational dividers. Digit outputs update atomically, so the display never shows a torn value. Sits between the snake game logic and the VGA score overlay.

Parameters:
SCORE_MAX, 999, saturation limit for score; must be ≤ 999 and < 1024.
POINTS_PER_FOOD, 1, amount added per eat pulse; range 1–15.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
game_start  input  1  1-cycle pulse; clears score and enables counting
eat  input  1  1-cycle pulse; adds POINTS_PER_FOOD
game_over  input  1  1-cycle pulse; freezes score
score  output  10  binary score
ones  output  4  BCD ones digit
tens  output  4  BCD tens digit
huns  output  4  BCD hundreds digit
busy  output  1  conversion in progress
hi_score  output  10  best score since reset (see Optional Feature)
new_high  output  1  1-cycle pulse when hi_score is raised

Behaviour:
- Reset (async, immediate):
  - score=0, ones=tens=huns=0, busy=0, hi_score=0, new_high=0.
  - FSM=IDLE, dirty=0, frozen=0, so counting is enabled after reset.
- Score update (edge k):
  - Condition: eat=1, frozen=0 and score<SCORE_MAX.
  - Action: score<=min(score+POINTS_PER_FOOD, SCORE_MAX); dirty<=1.
  - Compute the sum 11 bits wide before the min.
  - At SCORE_MAX, eat is ignored and dirty is not set.
- game_start (edge k):
  - score<=0, frozen<=0, dirty<=1.
  - Has priority over eat in the same cycle, which is dropped.
- game_over (edge k):
  - frozen<=1.
  - An eat in the same cycle is still counted; the score includes it.
  - game_over while already frozen does nothing.
  - game_start and game_over in the same cycle: game_start wins.
- While frozen, eat is ignored.
- FSM states: IDLE, SHIFT, LOAD.
  - IDLE: if dirty, capture score into a 10-bit shift register, clear the 12-bit BCD accumulator, dirty<=0, cnt<=0 → SHIFT. If a score update occurs in the same cycle, dirty stays 1, so a set has priority over a clear.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1; cnt++. After the 10th shift → LOAD.
  - LOAD: ones/tens/huns <= accumulator nibbles (single edge, atomic) → IDLE.
- busy = (state != IDLE).
- Latency: eat sampled at edge k → score valid after k → conversion captured at k+1 → shifts at k+2..k+11 → digits written at k+12.
- Score changes during a conversion leave dirty=1. After LOAD, a reconversion starts. The final digits always match the final score.
- The converted value is the snapshot taken at capture. Digits never reflect a partial conversion.
- Reset mid-conversion aborts it with no digit write; all registers return to their reset values.

Optional Feature:
Macro: SNAKE_HIGH_SCORE_EN.
- Defined:
  - On game_over while frozen=0, if the final score (including any same-cycle eat) > hi_score, then hi_score<=that score and new_high pulses for 1 cycle (the cycle after the game_over edge).
  - hi_score survives game_start; only reset clears it.
- Undefined:
  - hi_score is tied to 0 and new_high to 0.
  - No high-score register is synthesized.

Test Plan:
1. Reset, then 1 eat pulse → score=1 next cycle; busy rises after k+1; ones=1, tens=0, huns=0 after edge k+12; busy=0 after k+12.
2. 127 eat pulses spaced 20 cycles apart → final digits huns=1, tens=2, ones=7. Digits update only on LOAD edges, with no intermediate torn values.
3. 5 back-to-back eat pulses (one per cycle) → score=5. Conversion(s) rerun until the digits settle at 0/0/5. dirty=0 and busy=0 within 30 cycles of the last pulse.
4. Saturation with POINTS_PER_FOOD=7: drive score to 994, then 2 eats → score=999, then 999 again. The second eat sets no dirty and no extra busy. Digits read 9/9/9.
5. Simultaneous events:
   - game_over + eat at score=10 → score=11, frozen; a later eat gives no change.
   - game_start + eat → score=0.
   - With SNAKE_HIGH_SCORE_EN: hi_score=11 and new_high pulses once. A subsequent game scoring 5 → hi_score stays 11 and there is no pulse.
6. Assert reset during SHIFT, 5 cycles after an eat at score=42 → all outputs are 0 immediately (async); no LOAD occurs. After deassertion, one eat gives score=1 and digits 0/0/1.
